time_counter: RTL and testbench
===============================

TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL provide parameter DIV, default 1000, meaning clk_1kHz cycles per second.
REQ-002 SHALL provide port clk_1kHz, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL provide port key_mode, input, 1 bit: debounced one-cycle pulse that advances the mode.
REQ-005 SHALL provide port key_inc, input, 1 bit: debounced one-cycle pulse that increments the selected field.
REQ-006 SHALL provide port h_cntH, output, 4 bits: hour tens BCD, 0-2.
REQ-007 SHALL provide port h_cntL, output, 4 bits: hour units BCD, 0-9.
REQ-008 SHALL provide ports m_cntH and m_cntL, output, 4 bits each: minute tens (0-5) and units (0-9) BCD.
REQ-009 SHALL provide ports s_cntH and s_cntL, output, 4 bits each: second tens (0-5) and units (0-9) BCD.
REQ-010 SHALL provide port mode, output, 2 bits: 0=RUN, 1=SET_HOUR, 2=SET_MIN.
REQ-011 SHALL provide port sec_tick, output, 1 bit: one-cycle pulse on each running-second advance.

Function
REQ-012 SHALL register every output; no output is combinationally derived from an input.
REQ-013 SHALL keep a prescaler counting 0..DIV-1; a tick occurs in the cycle the prescaler equals DIV-1, after which it wraps to 0.
REQ-014 SHALL, in RUN on a tick, advance the time by one second; the new value is visible on the next edge, so the first advance after reset release appears DIV cycles later.
REQ-015 SHALL assert sec_tick for exactly the cycle in which the new second value first appears, and only in RUN.
REQ-016 SHALL wrap s_cntL 9->0 with a carry into s_cntH; on 59->00 it SHALL increment minutes in the same cycle.
REQ-017 SHALL wrap minutes 59->00 with a carry into hours in the same cycle, and hours 23->00; 23:59:59 -> 00:00:00 on a single tick.
REQ-018 SHALL never present a non-BCD digit or an out-of-range field value (hour >23, minute or second >59).
REQ-019 SHALL implement the mode FSM: RUN -key_mode-> SET_HOUR -key_mode-> SET_MIN -key_mode-> RUN; the only encoding not listed (3) SHALL go to RUN on the next edge.
REQ-020 SHALL hold the prescaler at 0 and freeze the seconds while in SET_HOUR or SET_MIN.
REQ-021 SHALL, in SET_HOUR, apply key_inc as hour+1 with wrap 23->00, leaving minutes and seconds unchanged.
REQ-022 SHALL, in SET_MIN, apply key_inc as minute+1 with wrap 59->00, with no carry into hours.
REQ-023 SHALL ignore key_inc in RUN.
REQ-024 SHALL, on the SET_MIN->RUN transition, clear the seconds to 00 and the prescaler to 0, then restart counting.
REQ-025 SHALL give key_mode priority when key_mode and key_inc are high in the same cycle: the mode advances and key_inc is discarded.
REQ-026 SHALL react to a key pulse held high for N cycles as N separate events; filtering is done upstream.

Reset
REQ-027 SHALL, while rst_n=0 and independent of the clock, force time 00:00:00, mode=RUN, prescaler=0 and sec_tick=0.
REQ-028 SHALL, after reset is released mid-operation, behave exactly as after power-up reset, with no residual tick or key effect.

Verification
REQ-029 Release reset, run 1000 cycles -> s_cntL=1 at cycle 1000, sec_tick high for that single cycle, all other digits 0.
REQ-030 Set 23:59 via the keys, return to RUN, run 59 s plus one tick -> 00:00:00, with all six digits changing in one edge.
REQ-031 In SET_HOUR at 23, pulse key_inc -> hour 00, minutes unchanged; in SET_MIN at 59, pulse key_inc -> minute 00, hour unchanged.
REQ-032 In SET_HOUR, assert key_mode and key_inc together -> mode=2, hour unchanged.
REQ-033 In RUN at 12:34:56 with the prescaler at 500, drop rst_n between clock edges -> outputs become 00:00:00 and mode=0 immediately; the next advance comes 1000 cycles after release.
REQ-034 With seconds at 37, cycle through the modes back to RUN -> s=00, and the first sec_tick comes 1000 cycles later.

Source files
------------

// File: rtl/time_counter.sv
// 24-hour BCD time-of-day counter with a key-driven set mode.
// A prescaler divides clk_1kHz down to seconds; hours and minutes can be set with two keys.
//
// state    | meaning
// ---------+--------------------------------------------------------
// RUN      | time advances once per DIV cycles, key_inc ignored
// SET_HOUR | prescaler held at 0, key_inc bumps hours (23 -> 00)
// SET_MIN  | prescaler held at 0, key_inc bumps minutes (59 -> 00, no carry)
// BAD      | unused encoding, recovers to RUN on the next edge
module time_counter #(
  parameter int DIV = 1000
) (
  input  logic       clk_1kHz,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [3:0] h_cntH,
  output logic [3:0] h_cntL,
  output logic [3:0] m_cntH,
  output logic [3:0] m_cntL,
  output logic [3:0] s_cntH,
  output logic [3:0] s_cntL,
  output logic [1:0] mode,
  output logic       sec_tick
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    BAD      = 2'd3
  } mode_e;

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  mode_e         mode_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    h_hi_q, h_lo_q, m_hi_q, m_lo_q, s_hi_q, s_lo_q;
  logic          sec_tick_q;

  logic       tick;
  logic [3:0] s_hi_d, s_lo_d, m_hi_d, m_lo_d, h_hi_d, h_lo_d;
  logic       sec_carry, min_carry;

  assign tick = (presc_q == PRESC_LAST);

  // Each field's "+1 with wrap" value; carries tell whether the next field moves on a tick.
  always_comb begin
    s_lo_d    = s_lo_q + 4'd1;
    s_hi_d    = s_hi_q;
    sec_carry = 1'b0;
    if (s_lo_q == 4'd9) begin
      s_lo_d = 4'd0;
      if (s_hi_q == 4'd5) begin
        s_hi_d    = 4'd0;
        sec_carry = 1'b1;
      end else begin
        s_hi_d = s_hi_q + 4'd1;
      end
    end

    m_lo_d    = m_lo_q + 4'd1;
    m_hi_d    = m_hi_q;
    min_carry = 1'b0;
    if (m_lo_q == 4'd9) begin
      m_lo_d = 4'd0;
      if (m_hi_q == 4'd5) begin
        m_hi_d    = 4'd0;
        min_carry = 1'b1;
      end else begin
        m_hi_d = m_hi_q + 4'd1;
      end
    end

    h_lo_d = h_lo_q + 4'd1;
    h_hi_d = h_hi_q;
    if (h_hi_q == 4'd2 && h_lo_q == 4'd3) begin
      h_lo_d = 4'd0;
      h_hi_d = 4'd0;
    end else if (h_lo_q == 4'd9) begin
      h_lo_d = 4'd0;
      h_hi_d = h_hi_q + 4'd1;
    end
  end

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= RUN;
      presc_q    <= '0;
      h_hi_q     <= 4'd0;
      h_lo_q     <= 4'd0;
      m_hi_q     <= 4'd0;
      m_lo_q     <= 4'd0;
      s_hi_q     <= 4'd0;
      s_lo_q     <= 4'd0;
      sec_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      case (mode_q)
        RUN: begin
          // key_mode wins over a coincident tick: the clock freezes on entry to SET_HOUR
          if (key_mode) begin
            mode_q  <= SET_HOUR;
            presc_q <= '0;
          end else if (tick) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b1;
            s_lo_q     <= s_lo_d;
            s_hi_q     <= s_hi_d;
            if (sec_carry) begin
              m_lo_q <= m_lo_d;
              m_hi_q <= m_hi_d;
              if (min_carry) begin
                h_lo_q <= h_lo_d;
                h_hi_q <= h_hi_d;
              end
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        SET_HOUR: begin
          presc_q <= '0;
          if (key_mode) begin
            mode_q <= SET_MIN;
          end else if (key_inc) begin
            h_lo_q <= h_lo_d;
            h_hi_q <= h_hi_d;
          end
        end
        SET_MIN: begin
          presc_q <= '0;
          if (key_mode) begin
            mode_q <= RUN;
            s_lo_q <= 4'd0;
            s_hi_q <= 4'd0;
          end else if (key_inc) begin
            m_lo_q <= m_lo_d;
            m_hi_q <= m_hi_d;
          end
        end
        default: begin
          mode_q  <= RUN;
          presc_q <= '0;
        end
      endcase
    end
  end

  assign h_cntH   = h_hi_q;
  assign h_cntL   = h_lo_q;
  assign m_cntH   = m_hi_q;
  assign m_cntL   = m_lo_q;
  assign s_cntH   = s_hi_q;
  assign s_cntL   = s_lo_q;
  assign mode     = mode_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: a seconds-of-day reference model feeds a scoreboard queue
// checked every cycle by a monitor, plus directed checks at the interesting boundaries.
module tb_time_counter;

  localparam int DIV = 1000;

  logic       clk_1kHz = 1'b0;
  logic       rst_n;
  logic       key_mode;
  logic       key_inc;
  logic [3:0] h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL;
  logic [1:0] mode;
  logic       sec_tick;

  int total = 0;
  int bad   = 0;
  int shown = 0;

  time_counter #(.DIV(DIV)) dut (
    .clk_1kHz (clk_1kHz),
    .rst_n    (rst_n),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .h_cntH   (h_cntH),
    .h_cntL   (h_cntL),
    .m_cntH   (m_cntH),
    .m_cntL   (m_cntL),
    .s_cntH   (s_cntH),
    .s_cntL   (s_cntL),
    .mode     (mode),
    .sec_tick (sec_tick)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  function automatic logic [26:0] pack(int hh, int mm, int ss, int md, int tk);
    pack = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10), 2'(md), 1'(tk)};
  endfunction

  function automatic logic [26:0] dut_vec();
    dut_vec = {h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL, mode, sec_tick};
  endfunction

  task automatic check(string name, logic [26:0] act, logic [26:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (shown < 30) begin
        shown++;
        $display("FAIL %s: got hhmmss/mode/tick=%h required=%h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: time as seconds of the day, plain arithmetic only.
  int m_tod = 0, m_mode = 0, m_presc = 0, m_tick = 0;
  logic [26:0] exp_q[$];
  bit mon_on = 1'b0;

  always @(posedge clk_1kHz) begin
    if (!rst_n) begin
      m_tod = 0; m_mode = 0; m_presc = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      case (m_mode)
        0: begin
          if (key_mode) begin
            m_mode = 1; m_presc = 0;
          end else if (m_presc == DIV - 1) begin
            m_presc = 0; m_tod = (m_tod + 1) % 86400; m_tick = 1;
          end else begin
            m_presc++;
          end
        end
        1: begin
          if (key_mode) m_mode = 2;
          else if (key_inc) m_tod = ((m_tod / 3600 + 1) % 24) * 3600 + m_tod % 3600;
        end
        default: begin
          if (key_mode) begin
            m_mode = 0; m_tod = m_tod - m_tod % 60;
          end else if (key_inc) begin
            m_tod = (m_tod / 3600) * 3600 + (((m_tod / 60) % 60 + 1) % 60) * 60 + m_tod % 60;
          end
        end
      endcase
    end
    if (mon_on) exp_q.push_back(pack(m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_mode, m_tick));
  end

  always @(posedge clk_1kHz) begin
    #1;
    if (mon_on) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
        check("scoreboard", dut_vec(), exp_q.pop_front());
      end
    end
  end

  task automatic idle(int n);
    key_mode = 1'b0; key_inc = 1'b0;
    repeat (n) @(negedge clk_1kHz);
  endtask

  task automatic pulse(logic km, logic ki);
    key_mode = km; key_inc = ki;
    @(negedge clk_1kHz);
    key_mode = 1'b0; key_inc = 1'b0;
  endtask

  task automatic cycles_to_tick(string name);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk_1kHz);
      cnt++;
    end while (!sec_tick && cnt < 2 * DIV);
    total++;
    if (cnt != DIV) begin
      bad++;
      $display("FAIL %s: first sec_tick after %0d cycles, required %0d", name, cnt, DIV);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    #2;
    check("reset_state", dut_vec(), pack(0, 0, 0, 0, 0));
    repeat (3) @(negedge clk_1kHz);
    mon_on = 1'b1;
    rst_n  = 1'b1;

    idle(DIV - 1);
    check("before_first_sec", dut_vec(), pack(0, 0, 0, 0, 0));
    idle(1);
    check("first_sec", dut_vec(), pack(0, 0, 1, 0, 1));
    idle(1);
    check("tick_one_cycle", dut_vec(), pack(0, 0, 1, 0, 0));

    pulse(1'b1, 1'b0);
    repeat (23) pulse(1'b0, 1'b1);
    check("hour_set_23", dut_vec(), pack(23, 0, 1, 1, 0));
    pulse(1'b0, 1'b1);
    check("hour_wrap", dut_vec(), pack(0, 0, 1, 1, 0));
    repeat (23) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    check("mode_priority", dut_vec(), pack(23, 0, 1, 2, 0));
    repeat (59) pulse(1'b0, 1'b1);
    check("min_set_59", dut_vec(), pack(23, 59, 1, 2, 0));
    pulse(1'b0, 1'b1);
    check("min_wrap_no_carry", dut_vec(), pack(23, 0, 1, 2, 0));
    repeat (59) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    check("run_clears_secs", dut_vec(), pack(23, 59, 0, 0, 0));

    idle(59 * DIV);
    check("at_235959", dut_vec(), pack(23, 59, 59, 0, 1));
    idle(DIV - 1);
    check("hold_235959", dut_vec(), pack(23, 59, 59, 0, 0));
    idle(1);
    check("midnight_rollover", dut_vec(), pack(0, 0, 0, 0, 1));

    idle(3 * DIV + 400);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    check("mode_cycle_secs", dut_vec(), pack(1, 1, 0, 0, 0));
    cycles_to_tick("mode_cycle_restart");

    idle(DIV / 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), pack(0, 0, 0, 0, 0));
    idle(2);
    rst_n = 1'b1;
    cycles_to_tick("post_reset_restart");

    for (int i = 0; i < 3000; i++) begin
      key_mode = ($urandom_range(0, 39) == 0);
      key_inc  = ($urandom_range(0, 3) == 0);
      @(negedge clk_1kHz);
    end
    idle(1500);
    mon_on = 1'b0;
    idle(2);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
